// File: rtl/secuenciador_entrada.sv
// Operand-entry sequencer: synchronizes and debounces two active-low keys and
// steps A -> B -> operation -> store, issuing one-cycle active-low load strobes.
module secuenciador_entrada #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keyNext,
  input  logic       keyBack,
  output logic       enA,
  output logic       enB,
  output logic       enO,
  output logic       enS,
  output logic [3:0] stateLEDs
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  // Compared before the increment, so a match here is the DEB_CYCLES-th differing edge.
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  localparam int unsigned KeyNextIdx = 0;
  localparam int unsigned KeyBackIdx = 1;

  typedef enum logic [1:0] {StA, StB, StO, StS} state_e;

  logic [1:0]      key_raw;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      deb_q;
  logic [1:0]      press_q;
  logic [CntW-1:0] cnt_q [2];
  state_e          state_q;

  assign key_raw = {keyBack, keyNext};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntLast) begin
          deb_q[i]   <= sync2_q[i];
          cnt_q[i]   <= '0;
          // Only the debounced fall (press) is an event; releases are silent.
          press_q[i] <= ~sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StA;
      enA       <= 1'b1;
      enB       <= 1'b1;
      enO       <= 1'b1;
      enS       <= 1'b1;
      stateLEDs <= 4'b0001;
    end else begin
      enA <= 1'b1;
      enB <= 1'b1;
      enO <= 1'b1;
      enS <= 1'b1;
      // Back has priority over a simultaneous next and never strobes.
      if (press_q[KeyBackIdx]) begin
        state_q   <= StA;
        stateLEDs <= 4'b0001;
      end else if (press_q[KeyNextIdx]) begin
        unique case (state_q)
          StA: begin
            state_q   <= StB;
            enA       <= 1'b0;
            stateLEDs <= 4'b0010;
          end
          StB: begin
            state_q   <= StO;
            enB       <= 1'b0;
            stateLEDs <= 4'b0100;
          end
          StO: begin
            state_q   <= StS;
            enO       <= 1'b0;
            stateLEDs <= 4'b1000;
          end
          StS: begin
            state_q   <= StA;
            enS       <= 1'b0;
            stateLEDs <= 4'b0001;
          end
          default: begin
            state_q   <= StA;
            stateLEDs <= 4'b0001;
          end
        endcase
      end
    end
  end

endmodule
